// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle MIPS controller.
// Holds the opcode constants, ALU operation codes, mux selector codes,
// the 12-state FSM encoding and the packed control word that the output
// decoder produces.
package ctrl_pkg;

  // Opcode field (IR[31:26])
  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU operation codes (shared with the single-cycle main decoder)
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_BEQ   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_BNE   = 3'b011;
  localparam logic [2:0] ALU_ORI   = 3'b100;
  localparam logic [2:0] ALU_LUI   = 3'b101;
  localparam logic [2:0] ALU_SLTIU = 3'b110;

  // ALU B operand select
  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_EXEC_I   = 4'd9,
    S_I_WB     = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
  } ctrl_word_t;

  // ALU operation for the immediate-arithmetic group.
  function automatic logic [2:0] i_alu_op(input logic [5:0] op);
    case (op)
      OP_SLTIU: i_alu_op = ALU_SLTIU;
      OP_ORI:   i_alu_op = ALU_ORI;
      OP_LUI:   i_alu_op = ALU_LUI;
      default:  i_alu_op = ALU_ADD;
    endcase
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTIU,
      OP_ORI, OP_LUI, OP_LW, OP_SW: is_legal = 1'b1;
      default:                      is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: bundle between the controller and the datapath.
// Inputs to the controller: instr_op_i (IR opcode), mem_ready_i (memory
// completes this cycle). Outputs: all datapath control strobes, the
// instr_done_o / illegal_o pulses, retired_cnt_o and the state_o debug view.
// Modports: master = controller side, slave = datapath / bench side.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  import ctrl_pkg::*;

  logic [5:0]       instr_op_i;
  logic             mem_ready_i;
  logic             PCWrite_o;
  logic             PCWriteCond_o;
  logic             BranchNe_o;
  logic             IorD_o;
  logic             MemRead_o;
  logic             MemWrite_o;
  logic             IRWrite_o;
  logic             MemtoReg_o;
  logic             RegDst_o;
  logic             RegWrite_o;
  logic             ALUSrcA_o;
  logic [1:0]       ALUSrcB_o;
  logic [2:0]       ALU_op_o;
  logic [1:0]       PCSource_o;
  logic             instr_done_o;
  logic             illegal_o;
  logic [CNT_W-1:0] retired_cnt_o;
  state_e           state_o;

  modport master (
    input  instr_op_i, mem_ready_i,
    output PCWrite_o, PCWriteCond_o, BranchNe_o, IorD_o, MemRead_o,
           MemWrite_o, IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o,
           ALUSrcA_o, ALUSrcB_o, ALU_op_o, PCSource_o, instr_done_o,
           illegal_o, retired_cnt_o, state_o
  );

  modport slave (
    output instr_op_i, mem_ready_i,
    input  PCWrite_o, PCWriteCond_o, BranchNe_o, IorD_o, MemRead_o,
           MemWrite_o, IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o,
           ALUSrcA_o, ALUSrcB_o, ALU_op_o, PCSource_o, instr_done_o,
           illegal_o, retired_cnt_o, state_o
  );

endinterface

// File: rtl/mc_ctrl_outputs.sv
// mc_ctrl_outputs: combinational control-word decoder.
// Ports: state_i (current FSM state), instr_op_i (IR opcode),
// mem_ready_i (memory handshake), ctrl_o (full control word, ungated).
// Strobes not named for a state stay 0.
module mc_ctrl_outputs
  import ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] instr_op_i,
  input  logic       mem_ready_i,
  output ctrl_word_t ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        // IR and PC+4 are captured only when the read actually completes.
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_BOFF;
        ctrl_o.illegal   = ~is_legal(instr_op_i);
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_RTYPE;
      end
      S_R_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.alu_op     = ALU_RTYPE;
        ctrl_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.instr_done    = 1'b1;
        ctrl_o.branch_ne     = (instr_op_i == OP_BNE);
        ctrl_o.alu_op        = (instr_op_i == OP_BNE) ? ALU_BNE : ALU_BEQ;
      end
      S_EXEC_I: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = i_alu_op(instr_op_i);
      end
      S_I_WB: begin
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = SRCB_IMM;
        ctrl_o.alu_op     = i_alu_op(instr_op_i);
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing the multi-cycle MIPS datapath.
// Ports: clk_i (rising edge), rst_i (synchronous, active-high),
// bus (multicycle_ctrl_if master: opcode + memory ready in, control
// strobes, retirement/illegal pulses, retired counter and state out).
// Handshake: the memory owns completion; in FETCH, MEM_RD and MEM_WR the
// request is held every cycle and the FSM advances only in the cycle
// mem_ready_i is high, which is also the only cycle side effects commit.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  multicycle_ctrl_if.master bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  ctrl_word_t       raw_cw, cw;

  mc_ctrl_outputs u_outputs (
    .state_i     (state_q),
    .instr_op_i  (bus.instr_op_i),
    .mem_ready_i (bus.mem_ready_i),
    .ctrl_o      (raw_cw)
  );

  // During reset no architectural state may change, so every write enable
  // and both pulses are suppressed; muxes still follow the state.
  always_comb begin
    cw = raw_cw;
    if (rst_i) begin
      cw.pc_write      = 1'b0;
      cw.pc_write_cond = 1'b0;
      cw.ir_write      = 1'b0;
      cw.mem_write     = 1'b0;
      cw.reg_write     = 1'b0;
      cw.instr_done    = 1'b0;
      cw.illegal       = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (bus.mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.instr_op_i)
          OP_LW, OP_SW:                          state_d = S_MEM_ADDR;
          OP_R:                                  state_d = S_EXEC_R;
          OP_BEQ, OP_BNE:                        state_d = S_BRANCH;
          OP_ADDI, OP_SLTIU, OP_ORI, OP_LUI:     state_d = S_EXEC_I;
          OP_J:                                  state_d = S_JUMP;
          default:                               state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (bus.instr_op_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (bus.mem_ready_i) state_d = S_MEM_WB;
      S_MEM_WR:   if (bus.mem_ready_i) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_R_WB;
      S_EXEC_I:   state_d = S_I_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cw.instr_done) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.PCWrite_o     = cw.pc_write;
  assign bus.PCWriteCond_o = cw.pc_write_cond;
  assign bus.BranchNe_o    = cw.branch_ne;
  assign bus.IorD_o        = cw.iord;
  assign bus.MemRead_o     = cw.mem_read;
  assign bus.MemWrite_o    = cw.mem_write;
  assign bus.IRWrite_o     = cw.ir_write;
  assign bus.MemtoReg_o    = cw.mem_to_reg;
  assign bus.RegDst_o      = cw.reg_dst;
  assign bus.RegWrite_o    = cw.reg_write;
  assign bus.ALUSrcA_o     = cw.alu_src_a;
  assign bus.ALUSrcB_o     = cw.alu_src_b;
  assign bus.ALU_op_o      = cw.alu_op;
  assign bus.PCSource_o    = cw.pc_source;
  assign bus.instr_done_o  = cw.instr_done;
  assign bus.illegal_o     = cw.illegal;
  assign bus.retired_cnt_o = cnt_q;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed bench for multicycle_ctrl.
// A 16-bit-counter instance carries the instruction tests; a second
// instance with a 2-bit counter checks counter wrap.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(16)) bus ();
  multicycle_ctrl_if #(.CNT_W(2))  bus2 ();

  multicycle_ctrl #(.CNT_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  multicycle_ctrl #(.CNT_W(2)) dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus2.master)
  );

  // Word layout: pcw pcwc bne iord mrd mwr irw m2r rdst rw srca srcb[2] op[3] pcsrc[2] done ill
  function automatic logic [19:0] mk(
    input logic pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca,
    input logic [1:0] srcb, input logic [2:0] aluop, input logic [1:0] pcsrc,
    input logic done, ill);
    return {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca,
            srcb, aluop, pcsrc, done, ill};
  endfunction

  function automatic logic [19:0] obs();
    return {bus.PCWrite_o, bus.PCWriteCond_o, bus.BranchNe_o, bus.IorD_o,
            bus.MemRead_o, bus.MemWrite_o, bus.IRWrite_o, bus.MemtoReg_o,
            bus.RegDst_o, bus.RegWrite_o, bus.ALUSrcA_o, bus.ALUSrcB_o,
            bus.ALU_op_o, bus.PCSource_o, bus.instr_done_o, bus.illegal_o};
  endfunction

  // Hand-written expected control words per state
  localparam logic [19:0] W_F0    = mk(0,0,0,0,1,0,0,0,0,0,0,2'b01,3'b000,2'b00,0,0);
  localparam logic [19:0] W_F1    = mk(1,0,0,0,1,0,1,0,0,0,0,2'b01,3'b000,2'b00,0,0);
  localparam logic [19:0] W_DEC   = mk(0,0,0,0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,0,0);
  localparam logic [19:0] W_DECIL = mk(0,0,0,0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,0,1);
  localparam logic [19:0] W_EXR   = mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0,0);
  localparam logic [19:0] W_RWB   = mk(0,0,0,0,0,0,0,0,1,1,0,2'b00,3'b010,2'b00,1,0);
  localparam logic [19:0] W_MADDR = mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0,0);
  localparam logic [19:0] W_MRD   = mk(0,0,0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0);
  localparam logic [19:0] W_MWB   = mk(0,0,0,0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,1,0);
  localparam logic [19:0] W_BNE   = mk(0,1,1,0,0,0,0,0,0,0,1,2'b00,3'b011,2'b01,1,0);
  localparam logic [19:0] W_BEQ   = mk(0,1,0,0,0,0,0,0,0,0,1,2'b00,3'b001,2'b01,1,0);
  localparam logic [19:0] W_JMP   = mk(1,0,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1,0);

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [19:0] ew [3];
    bus.instr_op_i = 6'b000000; bus.mem_ready_i = 1'b0;
    #1;
    checks++;
    if (bus.state_o !== S_FETCH || bus.retired_cnt_o !== 16'd0) begin
      failures++;
      $display("FAIL reset_state state=%0d cnt=%0d expected state=0 cnt=0", bus.state_o, bus.retired_cnt_o);
    end
    checks++;
    if (obs() !== W_F0) begin
      failures++; $display("FAIL reset_word got=%h expected=%h", obs(), W_F0);
    end
    // one jump so the counter is non-zero before the abort
    ew = '{W_F1, W_DEC, W_JMP};
    for (int i = 0; i < 3; i++) begin
      bus.instr_op_i = OP_J; bus.mem_ready_i = 1'b1;
      #1;
      checks++;
      if (obs() !== ew[i]) begin
        failures++; $display("FAIL jump_pre cyc%0d got=%h expected=%h", i, obs(), ew[i]);
      end
      step();
    end
    checks++;
    if (bus.retired_cnt_o !== 16'd1) begin
      failures++; $display("FAIL jump_pre_cnt got=%0d expected=1", bus.retired_cnt_o);
    end
    // walk a store to MEM_WR: FETCH, DECODE, MEM_ADDR
    bus.instr_op_i = OP_SW; bus.mem_ready_i = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.MemWrite_o !== 1'b0 || bus.instr_done_o !== 1'b0 || bus.RegWrite_o !== 1'b0) begin
        failures++;
        $display("FAIL reset_gating cyc%0d memwrite=%b done=%b regwrite=%b expected 0", i,
                 bus.MemWrite_o, bus.instr_done_o, bus.RegWrite_o);
      end
      if (i == 0) begin
        checks++;
        if (bus.IorD_o !== 1'b1) begin
          failures++; $display("FAIL reset_iord got=%b expected=1", bus.IorD_o);
        end
      end
      step();
    end
    rst = 1'b0; bus.mem_ready_i = 1'b0;
    #1;
    checks++;
    if (bus.state_o !== S_FETCH || bus.retired_cnt_o !== 16'd0) begin
      failures++;
      $display("FAIL reset_abort state=%0d cnt=%0d expected state=0 cnt=0", bus.state_o, bus.retired_cnt_o);
    end
  endtask

  task automatic test_add();
    logic [19:0] ew [4];
    ew = '{W_F1, W_DEC, W_EXR, W_RWB};
    for (int i = 0; i < 4; i++) begin
      bus.instr_op_i = OP_R; bus.mem_ready_i = 1'b1;
      #1;
      checks++;
      if (obs() !== ew[i]) begin
        failures++; $display("FAIL add cyc%0d got=%h expected=%h", i, obs(), ew[i]);
      end
      step();
    end
    checks++;
    if (bus.retired_cnt_o !== 16'd1 || bus.state_o !== S_FETCH) begin
      failures++;
      $display("FAIL add_retire cnt=%0d state=%0d expected cnt=1 state=0", bus.retired_cnt_o, bus.state_o);
    end
  endtask

  task automatic test_lw_wait();
    logic [19:0] ew [10];
    logic        rd [10];
    int          irw = 0;
    ew = '{W_F0, W_F0, W_F1, W_DEC, W_MADDR, W_MRD, W_MRD, W_MRD, W_MRD, W_MWB};
    rd = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      // opcode is garbage while fetching; must be ignored
      bus.instr_op_i = (i < 3) ? 6'b111111 : OP_LW;
      bus.mem_ready_i = rd[i];
      #1;
      if (bus.IRWrite_o === 1'b1) irw++;
      checks++;
      if (obs() !== ew[i]) begin
        failures++; $display("FAIL lw_wait cyc%0d got=%h expected=%h", i, obs(), ew[i]);
      end
      step();
    end
    checks++;
    if (irw != 1) begin
      failures++; $display("FAIL lw_irwrite_count got=%0d expected=1", irw);
    end
    checks++;
    if (bus.retired_cnt_o !== 16'd2 || bus.state_o !== S_FETCH) begin
      failures++;
      $display("FAIL lw_retire cnt=%0d state=%0d expected cnt=2 state=0", bus.retired_cnt_o, bus.state_o);
    end
  endtask

  task automatic test_branch();
    logic [19:0] ew [6];
    logic [5:0]  op [6];
    ew = '{W_F1, W_DEC, W_BNE, W_F1, W_DEC, W_BEQ};
    op = '{OP_BNE, OP_BNE, OP_BNE, OP_BEQ, OP_BEQ, OP_BEQ};
    for (int i = 0; i < 6; i++) begin
      bus.instr_op_i = op[i]; bus.mem_ready_i = 1'b1;
      #1;
      checks++;
      if (obs() !== ew[i]) begin
        failures++; $display("FAIL branch cyc%0d got=%h expected=%h", i, obs(), ew[i]);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  op [4];
    logic [2:0]  ao [4];
    logic [19:0] ew [4];
    logic [15:0] start;
    op = '{OP_ORI, OP_LUI, OP_SLTIU, OP_ADDI};
    ao = '{3'b100, 3'b101, 3'b110, 3'b000};
    start = bus.retired_cnt_o;
    for (int k = 0; k < 4; k++) begin
      ew = '{W_F1, W_DEC,
             mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,ao[k],2'b00,0,0),
             mk(0,0,0,0,0,0,0,0,0,1,1,2'b10,ao[k],2'b00,1,0)};
      for (int i = 0; i < 4; i++) begin
        bus.instr_op_i = op[k]; bus.mem_ready_i = 1'b1;
        #1;
        checks++;
        if (obs() !== ew[i]) begin
          failures++; $display("FAIL itype op%0d cyc%0d got=%h expected=%h", k, i, obs(), ew[i]);
        end
        step();
      end
    end
    checks++;
    if (bus.retired_cnt_o !== start + 16'd4) begin
      failures++; $display("FAIL itype_retire got=%0d expected=%0d", bus.retired_cnt_o, start + 16'd4);
    end
  endtask

  task automatic test_illegal();
    logic [19:0] ew [3];
    logic        rd [3];
    logic [15:0] start;
    ew = '{W_F1, W_DECIL, W_F0};
    rd = '{1'b1, 1'b0, 1'b0};
    start = bus.retired_cnt_o;
    for (int i = 0; i < 3; i++) begin
      bus.instr_op_i = 6'b111111; bus.mem_ready_i = rd[i];
      #1;
      checks++;
      if (obs() !== ew[i]) begin
        failures++; $display("FAIL illegal cyc%0d got=%h expected=%h", i, obs(), ew[i]);
      end
      if (i == 2) begin
        checks++;
        if (bus.state_o !== S_FETCH || bus.retired_cnt_o !== start) begin
          failures++;
          $display("FAIL illegal_after state=%0d cnt=%0d expected state=0 cnt=%0d",
                   bus.state_o, bus.retired_cnt_o, start);
        end
      end
      step();
    end
  endtask

  task automatic test_cnt_wrap();
    bus.mem_ready_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < 3; i++) begin
        bus2.instr_op_i = OP_J; bus2.mem_ready_i = 1'b1;
        #1;
        if (i == 2) begin
          checks++;
          if (bus2.PCWrite_o !== 1'b1 || bus2.instr_done_o !== 1'b1 || bus2.PCSource_o !== 2'b10) begin
            failures++;
            $display("FAIL wrap_jump j%0d pcw=%b done=%b pcsrc=%b expected 1 1 10", j,
                     bus2.PCWrite_o, bus2.instr_done_o, bus2.PCSource_o);
          end
        end
        step();
      end
      if (j == 3) begin
        checks++;
        if (bus2.retired_cnt_o !== 2'd0) begin
          failures++; $display("FAIL wrap_to_zero got=%0d expected=0", bus2.retired_cnt_o);
        end
      end
    end
    checks++;
    if (bus2.retired_cnt_o !== 2'd1) begin
      failures++; $display("FAIL wrap_five got=%0d expected=1", bus2.retired_cnt_o);
    end
  endtask

  initial begin
    bus.instr_op_i = 6'd0;  bus.mem_ready_i = 1'b0;
    bus2.instr_op_i = 6'd0; bus2.mem_ready_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_cnt_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
